// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Single-outstanding load/store initiator for a byte-laned data
//            memory. Optional alignment checking: MEM_ALIGN_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int unsigned MEM_BYTES = 524288
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_mem_ce,
  output logic        o_mem_wr_fg,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_sel,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ACCESS  = 2'd1;
  localparam logic [1:0] c_RESP    = 2'd2;

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;
  localparam logic [1:0] c_SZ_RSVD = 2'b11;

  localparam logic [32:0] c_MEM_LIMIT = 33'(MEM_BYTES);

  logic [1:0]  r_state;
  logic        r_is_store;
  logic        r_is_unsigned;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic        w_size_rsvd;
  logic        w_out_of_range;
  logic        w_misaligned;
  logic        w_req_err;
  logic [1:0]  w_off;
  logic [3:0]  w_sel_base;
  logic [31:0] w_wdata_base;
  logic [4:0]  w_shamt;
  logic [3:0]  w_sel;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_rd_shift;
  logic [31:0] w_load;
  logic        w_in_access;

  // Request validation looks at the incoming request so the decision is made
  // on the same edge the request is captured.
  always_comb begin
    w_size_rsvd    = (i_req_op[1:0] == c_SZ_RSVD);
    w_out_of_range = ({1'b0, i_req_addr} >= c_MEM_LIMIT);
`ifdef MEM_ALIGN_CHECK_EN
    w_misaligned   = ((i_req_op[1:0] == c_SZ_HALF) && i_req_addr[0]) ||
                     ((i_req_op[1:0] == c_SZ_WORD) && (i_req_addr[1:0] != 2'b00));
`else
    w_misaligned   = 1'b0;
`endif
    w_req_err      = w_size_rsvd || w_out_of_range || w_misaligned;
  end

  // Halfword/word offsets drop the low address bits, so an unchecked
  // misaligned access lands on the containing aligned unit.
  always_comb begin
    case (r_size)
      c_SZ_BYTE: begin
        w_off        = r_addr[1:0];
        w_sel_base   = 4'b0001;
        w_wdata_base = {24'd0, r_wdata[7:0]};
      end
      c_SZ_HALF: begin
        w_off        = {r_addr[1], 1'b0};
        w_sel_base   = 4'b0011;
        w_wdata_base = {16'd0, r_wdata[15:0]};
      end
      default: begin
        w_off        = 2'b00;
        w_sel_base   = 4'b1111;
        w_wdata_base = r_wdata;
      end
    endcase
  end

  assign w_shamt      = {w_off, 3'b000};
  assign w_sel        = w_sel_base << w_off;
  assign w_lane_wdata = w_wdata_base << w_shamt;
  assign w_rd_shift   = i_mem_rdata >> w_shamt;

  always_comb begin
    case (r_size)
      c_SZ_BYTE: w_load = {{24{~r_is_unsigned & w_rd_shift[7]}},  w_rd_shift[7:0]};
      c_SZ_HALF: w_load = {{16{~r_is_unsigned & w_rd_shift[15]}}, w_rd_shift[15:0]};
      default:   w_load = w_rd_shift;
    endcase
  end

  // Memory strobes are decoded from state so an asynchronous reset removes
  // the write flag before the next edge.
  assign w_in_access  = (r_state == c_ACCESS);
  assign o_mem_ce     = w_in_access;
  assign o_mem_wr_fg  = w_in_access & r_is_store;
  assign o_mem_addr   = w_in_access ? {r_addr[31:2], 2'b00} : 32'd0;
  assign o_mem_sel    = w_in_access ? w_sel : 4'd0;
  assign o_mem_wdata  = (w_in_access & r_is_store) ? w_lane_wdata : 32'd0;

  assign o_req_ready  = (r_state == c_IDLE);
  assign o_resp_valid = (r_state == c_RESP);
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_IDLE;
      r_is_store    <= 1'b0;
      r_is_unsigned <= 1'b0;
      r_size        <= 2'b00;
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_resp_rdata  <= 32'd0;
      r_resp_err    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_req_valid) begin
            r_is_store    <= i_req_op[3];
            r_is_unsigned <= i_req_op[2];
            r_size        <= i_req_op[1:0];
            r_addr        <= i_req_addr;
            r_wdata       <= i_req_wdata;
            if (w_req_err) begin
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
              r_state      <= c_RESP;
            end else begin
              r_state      <= c_ACCESS;
            end
          end
        end
        c_ACCESS: begin
          r_resp_err   <= 1'b0;
          r_resp_rdata <= r_is_store ? 32'd0 : w_load;
          r_state      <= c_RESP;
        end
        c_RESP: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
